uart_tx_stream: RTL

// - Serialises words from a valid/ready stream onto an asynchronous UART line (start, data LSB-first, optional parity, stop).
// - Sits at the output end of the stream datapath and drains results (e.g. from a skid buffer) to the host.
// - Acts as the stream consumer only; line timing is derived from clk by a fixed divider.

---
 rtl/uart_tx_stream.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: drains a valid/ready word stream onto an asynchronous UART
// line. Each frame is a start bit, WIDTH data bits LSB first, an optional
// parity bit, then STOP_BITS stop bits. Every bit lasts CLOCKS_PER_BIT clocks.
// The word is copied into a local shift register at the handshake, so the
// upstream side is free to change s_data/s_valid while the frame is on the line.
module uart_tx_stream #(
    parameter int CLOCKS_PER_BIT = 174,
    parameter int WIDTH          = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             tx,
    output logic             busy
);

    localparam int              CNT_W      = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [3:0]      DATA_LAST  = 4'(WIDTH - 1);
    localparam logic [3:0]      STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic            HAS_PARITY = (PARITY != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity of the accepted word: odd parity makes data+parity carry an odd
    // number of ones, even parity an even number.
    function automatic logic parity_bit(input logic [WIDTH-1:0] word);
        logic ones_odd;
        ones_odd = ^word;
        if (PARITY == 1) begin
            return ~ones_odd;
        end else begin
            return ones_odd;
        end
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] clk_cnt_r;
    logic [3:0]       bit_cnt_r;
    logic [WIDTH-1:0] shift_r;
    logic             par_r;
    logic             tx_r;
    logic             s_ready_r;
    logic             busy_r;
    logic             bit_end_s;

    assign bit_end_s = (clk_cnt_r == CNT_LAST);
    assign tx        = tx_r;
    assign s_ready   = s_ready_r;
    assign busy      = busy_r;

    // Frame sequencer: accepts a word, then walks start/data/parity/stop bits
    // with a per-bit clock counter; all outputs are registered here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            clk_cnt_r <= '0;
            bit_cnt_r <= 4'd0;
            shift_r   <= '0;
            par_r     <= 1'b0;
            tx_r      <= 1'b1;
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    clk_cnt_r <= '0;
                    bit_cnt_r <= 4'd0;
                    if (s_ready_r && s_valid) begin
                        shift_r   <= s_data;
                        par_r     <= parity_bit(s_data);
                        tx_r      <= 1'b0;
                        s_ready_r <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_START;
                    end else begin
                        tx_r      <= 1'b1;
                        s_ready_r <= 1'b1;
                        busy_r    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        clk_cnt_r <= '0;
                        bit_cnt_r <= 4'd0;
                        tx_r      <= shift_r[0];
                        state_r   <= ST_DATA;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        clk_cnt_r <= '0;
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_r <= 4'd0;
                            if (HAS_PARITY) begin
                                tx_r    <= par_r;
                                state_r <= ST_PARITY;
                            end else begin
                                tx_r    <= 1'b1;
                                state_r <= ST_STOP;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            shift_r   <= shift_r >> 1;
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        clk_cnt_r <= '0;
                        bit_cnt_r <= 4'd0;
                        tx_r      <= 1'b1;
                        state_r   <= ST_STOP;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        clk_cnt_r <= '0;
                        if (bit_cnt_r == STOP_LAST) begin
                            bit_cnt_r <= 4'd0;
                            s_ready_r <= 1'b1;
                            busy_r    <= 1'b0;
                            state_r   <= ST_IDLE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    clk_cnt_r <= '0;
                    bit_cnt_r <= 4'd0;
                    tx_r      <= 1'b1;
                    s_ready_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule
